config_sweep_checker: RTL and testbench

//  Sequencer that sweeps a 3-bit flag-configuration code (bit2=nest_one, bit1=nest_two,
//  bit0=nest_three) through every enabled combination. It drives the code to a DUT whose
//  3-bit output must equal the code, lets it settle, compares, and accumulates a

---
 rtl/config_sweep_pkg.sv | 15 +
 rtl/config_sweep_checker_next_code_finder.sv | 24 ++
 rtl/config_sweep_checker.sv | 136 +++++++++++++
 tb/tb_config_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/config_sweep_pkg.sv
// Shared definitions for the configuration-code sweep checker: code geometry and FSM states.
package config_sweep_pkg;

    localparam int unsigned CODE_W    = 3;
    localparam int unsigned NUM_CODES = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StApply  = 3'd1,
        StSettle = 3'd2,
        StCheck  = 3'd3,
        StDone   = 3'd4
    } state_t;

endpackage

// File: rtl/config_sweep_checker_next_code_finder.sv
// Finds the lowest enabled code (first=1) or the lowest enabled code above cur_code.
module next_code_finder
    import config_sweep_pkg::*;
(
    input  logic [CODE_W-1:0]    cur_code,
    input  logic [NUM_CODES-1:0] mask,
    input  logic                 first,
    output logic [CODE_W-1:0]    next_code,
    output logic                 found
);

    // Scan from the top down so the last hit is the lowest qualifying code.
    always_comb begin
        next_code = '0;
        found     = 1'b0;
        for (int i = int'(NUM_CODES) - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur_code)))) begin
                next_code = CODE_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_sweep_checker.sv
// Sweeps every enabled 3-bit configuration code through a DUT, compares its response
// after a settle delay, and accumulates a pass/fail verdict with first-failure capture.
module config_sweep_checker
    import config_sweep_pkg::*;
#(
    parameter int unsigned    SETTLE_CYCLES = 2,
    parameter int unsigned    CNT_W         = 4,
    parameter logic [7:0]     SWEEP_MASK    = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        dut_out,
    output logic [2:0]        cfg_code,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [2:0]        first_fail_code,
    output logic              first_fail_valid
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   cfg_q, cfg_d;
    logic [SET_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CODE_W-1:0]   ff_code_q, ff_code_d;
    logic                ff_valid_q, ff_valid_d;
    logic                pass_q, pass_d;

    logic [CODE_W-1:0]   nxt_code;
    logic                nxt_found;

    next_code_finder u_next_code_finder (
        .cur_code  (cfg_q),
        .mask      (SWEEP_MASK),
        .first     (state_q == StIdle),
        .next_code (nxt_code),
        .found     (nxt_found)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ff_code_d  = ff_code_q;
        ff_valid_d = ff_valid_q;
        pass_d     = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d      = '0;
                    ff_valid_d = 1'b0;
                    pass_d     = 1'b0;
                    if (nxt_found) begin
                        cfg_d   = nxt_code;
                        state_d = StApply;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StApply: begin
                cnt_d   = SET_W'(SETTLE_CYCLES);
                state_d = (SETTLE_CYCLES == 0) ? StCheck : StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SET_W'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (dut_out != cfg_q) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ff_valid_q) begin
                        ff_code_d  = cfg_q;
                        ff_valid_d = 1'b1;
                    end
                end
                if (nxt_found) begin
                    cfg_d   = nxt_code;
                    state_d = StApply;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Verdict is registered on entry so it is already valid during the done pulse.
        if (state_d == StDone) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cfg_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ff_code_q  <= '0;
            ff_valid_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ff_code_q  <= ff_code_d;
            ff_valid_q <= ff_valid_d;
            pass_q     <= pass_d;
        end
    end

    assign cfg_code         = cfg_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_code  = ff_code_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_config_sweep_checker.sv
// Randomized self-checking bench: four parameterisations swept in lockstep against a
// cycle-level reference model of sweep timing, code order and verdict.
module tb_config_sweep_checker;

    localparam int NI = 4;
    localparam int unsigned SP [NI] = '{2, 0, 1, 0};
    localparam int unsigned WP [NI] = '{4, 2, 2, 4};
    localparam logic [7:0]  MP [NI] = '{8'hFF, 8'h81, 8'hFE, 8'h00};

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a [NI];
    logic [2:0] dut_a   [NI];
    logic [2:0] cfg_a   [NI];
    logic       busy_a  [NI];
    logic       done_a  [NI];
    logic       pass_a  [NI];
    logic [3:0] err_a   [NI];
    logic [2:0] ffc_a   [NI];
    logic       ffv_a   [NI];
    logic [2:0] flip    [NI][8];

    int n_vec = 0;
    int n_bad = 0;
    int prev_cfg [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WP[g]-1:0] err_w;

        config_sweep_checker #(
            .SETTLE_CYCLES (SP[g]),
            .CNT_W         (WP[g]),
            .SWEEP_MASK    (MP[g])
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .start            (start_a[g]),
            .dut_out          (dut_a[g]),
            .cfg_code         (cfg_a[g]),
            .busy             (busy_a[g]),
            .done             (done_a[g]),
            .pass             (pass_a[g]),
            .err_count        (err_w),
            .first_fail_code  (ffc_a[g]),
            .first_fail_valid (ffv_a[g])
        );

        assign err_a[g] = 4'(err_w);
        // Modelled DUT: identity response corrupted by a per-code XOR pattern.
        assign dut_a[g] = cfg_a[g] ^ flip[g][cfg_a[g]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s[%0d].cfg_code", tag, k), 32'(cfg_a[k]), 0);
            check($sformatf("%s[%0d].busy", tag, k), 32'(busy_a[k]), 0);
            check($sformatf("%s[%0d].done", tag, k), 32'(done_a[k]), 0);
            check($sformatf("%s[%0d].pass", tag, k), 32'(pass_a[k]), 0);
            check($sformatf("%s[%0d].err_count", tag, k), 32'(err_a[k]), 0);
            check($sformatf("%s[%0d].ff_code", tag, k), 32'(ffc_a[k]), 0);
            check($sformatf("%s[%0d].ff_valid", tag, k), 32'(ffv_a[k]), 0);
        end
    endtask

    // mode 0: identity, 1: bit0 stuck at 0, 2: output stuck at 0, else random corruption.
    task automatic set_flip(input int mode);
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 8; c++) begin
                case (mode)
                    0:       flip[k][c] = 3'd0;
                    1:       flip[k][c] = 3'(c & 1);
                    2:       flip[k][c] = 3'(c);
                    default: flip[k][c] = ($urandom_range(0, 1) == 1) ?
                                          3'($urandom_range(1, 7)) : 3'd0;
                endcase
            end
        end
    endtask

    // One sweep on every instance; abort_at > 0 asserts reset during that cycle.
    task automatic run_sweep(input int abort_at);
        int         lst  [NI][8];
        int         n    [NI];
        int         p    [NI];
        int         d    [NI];
        int         nerr [NI];
        int         ffc  [NI];
        int         maxc;
        int         exp_cfg;
        int         sat;
        logic [7:0] m;

        maxc = 0;
        for (int k = 0; k < NI; k++) begin
            m       = MP[k];
            n[k]    = 0;
            nerr[k] = 0;
            ffc[k]  = -1;
            for (int c = 0; c < 8; c++) begin
                if (m[c]) begin
                    lst[k][n[k]] = c;
                    n[k]++;
                    if (flip[k][c] != 3'd0) begin
                        nerr[k]++;
                        if (ffc[k] < 0) ffc[k] = c;
                    end
                end
            end
            p[k] = int'(SP[k]) + 2;
            d[k] = n[k] * p[k] + 1;
            if (d[k] + 2 > maxc) maxc = d[k] + 2;
        end

        @(negedge clk);
        for (int k = 0; k < NI; k++) start_a[k] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) start_a[k] = 1'b0;

        for (int c = 1; c <= maxc; c++) begin
            if (c == abort_at) begin
                for (int k = 0; k < NI; k++) start_a[k] = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check_reset_state($sformatf("abort@%0d", c));
                for (int k = 0; k < NI; k++) prev_cfg[k] = 0;
                return;
            end
            for (int k = 0; k < NI; k++) begin
                if (n[k] == 0)      exp_cfg = prev_cfg[k];
                else if (c < d[k])  exp_cfg = lst[k][(c - 1) / p[k]];
                else                exp_cfg = lst[k][n[k] - 1];
                check($sformatf("c%0d[%0d].cfg_code", c, k), 32'(cfg_a[k]), exp_cfg);
                check($sformatf("c%0d[%0d].busy", c, k), 32'(busy_a[k]), (c <= d[k]) ? 1 : 0);
                check($sformatf("c%0d[%0d].done", c, k), 32'(done_a[k]), (c == d[k]) ? 1 : 0);
                check($sformatf("c%0d[%0d].pass", c, k), 32'(pass_a[k]),
                      (c < d[k]) ? 0 : ((nerr[k] == 0) ? 1 : 0));
                // Starts while busy, including the done cycle, must be ignored.
                start_a[k] = (c <= d[k]) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < NI; k++) begin
            sat = (1 << WP[k]) - 1;
            check($sformatf("end[%0d].err_count", k), 32'(err_a[k]),
                  (nerr[k] > sat) ? sat : nerr[k]);
            check($sformatf("end[%0d].ff_valid", k), 32'(ffv_a[k]), (nerr[k] > 0) ? 1 : 0);
            if (nerr[k] > 0) begin
                check($sformatf("end[%0d].ff_code", k), 32'(ffc_a[k]), ffc[k]);
            end
            if (n[k] > 0) prev_cfg[k] = lst[k][n[k] - 1];
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start_a[k]  = 1'b0;
            prev_cfg[k] = 0;
        end
        set_flip(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        set_flip(0);
        run_sweep(0);
        set_flip(1);
        run_sweep(0);
        set_flip(2);
        run_sweep(0);
        // Cycle 18 is the first settle cycle of code 4 on the default instance.
        set_flip(3);
        run_sweep(18);
        for (int i = 0; i < 6; i++) begin
            set_flip(3);
            run_sweep(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
